// File: rtl/led_sequencer.sv
// LED position sequencer: debounced button or auto timer steps a position that
// is shown on N_LEDS outputs in rotate, bounce, fill or hold style.
module led_sequencer #(
   parameter int N_LEDS          = 4,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int AUTO_DIV        = 16,
   parameter int PW              = $clog2(N_LEDS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic              button,
   input  logic              dir,
   input  logic [1:0]        mode,
   input  logic              auto_en,
   output logic [N_LEDS-1:0] led,
   output logic [PW-1:0]     pos,
   output logic              wrap
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int DW = $clog2(AUTO_DIV);
   localparam logic [PW-1:0] LAST_POS = PW'(N_LEDS - 1);
   localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(AUTO_DIV - 1);

   typedef enum logic [1:0] {
      MODE_ROTATE = 2'b00,
      MODE_BOUNCE = 2'b01,
      MODE_FILL   = 2'b10,
      MODE_HOLD   = 2'b11
   } mode_t;

   typedef enum logic {
      BDIR_UP   = 1'b0,
      BDIR_DOWN = 1'b1
   } bdir_t;

   mode_t             mode_cur;
   mode_t             mode_prev;
   bdir_t             bdir;
   bdir_t             bdir_eff;
   bdir_t             bdir_next;
   logic              s1;
   logic              s2;
   logic [1:0]        sync_ok;
   logic              db;
   logic              db_prev;
   logic [CW-1:0]     db_cnt;
   logic              armed;
   logic              btn_step;
   logic [DW-1:0]     presc;
   logic              auto_tick;
   logic              step;
   logic              pos_valid;
   logic [PW-1:0]     pos_next;
   logic              wrap_next;
   logic [N_LEDS-1:0] led_next;

   assign mode_cur = mode_t'(mode);

   // sync_ok marks when s2 holds a genuine post-reset sample of the button
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1      <= 1'b0;
         s2      <= 1'b0;
         sync_ok <= 2'b00;
      end else begin
         s1      <= button;
         s2      <= s1;
         sync_ok <= {sync_ok[0], 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         db     <= 1'b0;
         db_cnt <= '0;
      end else if (s2 != db) begin
         if (db_cnt == DB_LAST) begin
            db     <= s2;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + CW'(1);
         end
      end else begin
         db_cnt <= '0;
      end
   end

   // A button already held through reset must be seen low once before it may step
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         armed    <= 1'b0;
         db_prev  <= 1'b0;
         btn_step <= 1'b0;
      end else begin
         armed    <= armed | (sync_ok[1] & ~s2);
         db_prev  <= db;
         btn_step <= db & ~db_prev & armed;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc <= '0;
      end else if (!auto_en || presc == DIV_LAST) begin
         presc <= '0;
      end else begin
         presc <= presc + DW'(1);
      end
   end

   assign auto_tick = auto_en & (presc == DIV_LAST);
   assign step      = we & (btn_step | auto_tick);

   generate
      if (N_LEDS == (1 << PW)) begin : g_full_range
         assign pos_valid = 1'b1;
      end else begin : g_partial_range
         assign pos_valid = (pos <= LAST_POS);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pos       <= '0;
         wrap      <= 1'b0;
         bdir      <= BDIR_UP;
         mode_prev <= MODE_ROTATE;
         led       <= '0;
      end else begin
         pos       <= pos_next;
         wrap      <= wrap_next;
         bdir      <= bdir_next;
         mode_prev <= mode_cur;
         led       <= led_next;
      end
   end

   // Entering bounce re-seeds the direction so a move from the top end goes down
   always_comb begin
      pos_next  = pos;
      wrap_next = 1'b0;
      bdir_eff  = bdir;
      if (mode_cur == MODE_BOUNCE && mode_prev != MODE_BOUNCE) begin
         bdir_eff = (pos == LAST_POS) ? BDIR_DOWN : BDIR_UP;
      end
      bdir_next = bdir_eff;
      if (!pos_valid) begin
         pos_next = '0;
      end else if (step) begin
         case (mode_cur)
            MODE_ROTATE, MODE_FILL: begin
               if (!dir) begin
                  if (pos == LAST_POS) begin
                     pos_next  = '0;
                     wrap_next = 1'b1;
                  end else begin
                     pos_next = pos + PW'(1);
                  end
               end else begin
                  if (pos == '0) begin
                     pos_next  = LAST_POS;
                     wrap_next = 1'b1;
                  end else begin
                     pos_next = pos - PW'(1);
                  end
               end
            end
            MODE_BOUNCE: begin
               if (bdir_eff == BDIR_UP) begin
                  if (pos == LAST_POS) begin
                     pos_next  = LAST_POS - PW'(1);
                     bdir_next = BDIR_DOWN;
                  end else begin
                     pos_next = pos + PW'(1);
                     if (pos == LAST_POS - PW'(1)) begin
                        wrap_next = 1'b1;
                        bdir_next = BDIR_DOWN;
                     end
                  end
               end else begin
                  if (pos == '0) begin
                     pos_next  = PW'(1);
                     bdir_next = BDIR_UP;
                  end else begin
                     pos_next = pos - PW'(1);
                     if (pos == PW'(1)) begin
                        wrap_next = 1'b1;
                        bdir_next = BDIR_UP;
                     end
                  end
               end
            end
            default: begin
               pos_next = pos;
            end
         endcase
      end
   end

   always_comb begin
      led_next = '0;
      for (int i = 0; i < N_LEDS; i++) begin
         if (mode_cur == MODE_FILL) begin
            led_next[i] = (PW'(i) <= pos);
         end else begin
            led_next[i] = (PW'(i) == pos);
         end
      end
   end

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer: directed scenarios plus random presses
// compared against a behavioural position model.
module tb_led_sequencer;

   localparam int N   = 4;
   localparam int DB  = 4;
   localparam int DIV = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         we = 1'b0;
   logic         button = 1'b0;
   logic         dir = 1'b0;
   logic [1:0]   mode = 2'b00;
   logic         auto_en = 1'b0;
   logic [N-1:0] led;
   logic [1:0]   pos;
   logic         wrap;

   int total = 0;
   int bad   = 0;

   int m_pos  = 0;
   bit m_up   = 1'b1;
   int m_mode = 0;
   bit m_wrap = 1'b0;

   always #5 clk = ~clk;

   led_sequencer #(
      .N_LEDS(N),
      .DEBOUNCE_CYCLES(DB),
      .AUTO_DIV(DIV)
   ) dut (
      .clk(clk),
      .rst(rst),
      .we(we),
      .button(button),
      .dir(dir),
      .mode(mode),
      .auto_en(auto_en),
      .led(led),
      .pos(pos),
      .wrap(wrap)
   );

   function automatic logic [N-1:0] exp_led(input int p, input int md);
      int v;
      if (md == 2) v = (1 << (p + 1)) - 1;
      else         v = 1 << p;
      return v[N-1:0];
   endfunction

   task automatic model_set_mode(input int md);
      if (md == 1 && m_mode != 1) m_up = (m_pos != N - 1);
      m_mode = md;
   endtask

   task automatic model_step(input bit d);
      m_wrap = 1'b0;
      case (m_mode)
         0, 2: begin
            if (!d) begin
               m_pos  = (m_pos + 1) % N;
               m_wrap = (m_pos == 0);
            end else begin
               m_pos  = (m_pos + N - 1) % N;
               m_wrap = (m_pos == N - 1);
            end
         end
         1: begin
            m_pos = m_up ? m_pos + 1 : m_pos - 1;
            if (m_pos == N - 1 || m_pos == 0) begin
               m_wrap = 1'b1;
               m_up   = (m_pos == 0);
            end
         end
         default: m_wrap = 1'b0;
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press_check(input string name, input int hold);
      int old_pos;
      old_pos = m_pos;
      tick();
      button = 1'b1;
      repeat (7) tick();
      total++;
      if (pos !== 2'(old_pos)) begin
         bad++;
         $display("[TB] FAIL %s_early_pos: got %0d expected %0d", name, pos, old_pos);
      end
      tick();
      if (we) model_step(dir);
      else    m_wrap = 1'b0;
      total++;
      if (pos !== 2'(m_pos)) begin
         bad++;
         $display("[TB] FAIL %s_pos: got %0d expected %0d", name, pos, m_pos);
      end
      total++;
      if (wrap !== m_wrap) begin
         bad++;
         $display("[TB] FAIL %s_wrap: got %0b expected %0b", name, wrap, m_wrap);
      end
      tick();
      total++;
      if (led !== exp_led(m_pos, m_mode)) begin
         bad++;
         $display("[TB] FAIL %s_led: got %b expected %b", name, led, exp_led(m_pos, m_mode));
      end
      total++;
      if (wrap !== 1'b0) begin
         bad++;
         $display("[TB] FAIL %s_wrap_pulse: got %0b expected 0", name, wrap);
      end
      if (hold > 9) repeat (hold - 9) tick();
      button = 1'b0;
      repeat (12) tick();
      total++;
      if (pos !== 2'(m_pos)) begin
         bad++;
         $display("[TB] FAIL %s_release_pos: got %0d expected %0d", name, pos, m_pos);
      end
   endtask

   task automatic test_reset();
      #12;
      total++;
      if (led !== 4'b0000) begin
         bad++;
         $display("[TB] FAIL reset_led: got %b expected 0000", led);
      end
      total++;
      if (pos !== 2'd0) begin
         bad++;
         $display("[TB] FAIL reset_pos: got %0d expected 0", pos);
      end
      total++;
      if (wrap !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_wrap: got %0b expected 0", wrap);
      end
      @(negedge clk);
      rst = 1'b1;
      tick();
      total++;
      if (led !== 4'b0001) begin
         bad++;
         $display("[TB] FAIL release_led: got %b expected 0001", led);
      end
      total++;
      if (pos !== 2'd0 || wrap !== 1'b0) begin
         bad++;
         $display("[TB] FAIL release_pos_wrap: got %0d/%0b expected 0/0", pos, wrap);
      end
   endtask

   task automatic test_rotate();
      tick();
      we = 1'b1; dir = 1'b0; mode = 2'b00;
      model_set_mode(0);
      for (int i = 0; i < 4; i++) press_check("rotate", 10);
   endtask

   task automatic test_glitch_and_we();
      tick();
      button = 1'b1;
      tick();
      tick();
      button = 1'b0;
      repeat (15) tick();
      total++;
      if (pos !== 2'(m_pos) || led !== exp_led(m_pos, m_mode)) begin
         bad++;
         $display("[TB] FAIL glitch: got pos %0d led %b expected pos %0d led %b",
                  pos, led, m_pos, exp_led(m_pos, m_mode));
      end
      we = 1'b0;
      press_check("we_off", 10);
      we = 1'b1;
   endtask

   task automatic test_bounce_auto();
      tick();
      mode = 2'b01;
      model_set_mode(1);
      tick();
      auto_en = 1'b1;
      for (int s = 0; s < 8; s++) begin
         repeat (15) tick();
         total++;
         if (pos !== 2'(m_pos)) begin
            bad++;
            $display("[TB] FAIL bounce_hold_%0d: got %0d expected %0d", s, pos, m_pos);
         end
         tick();
         model_step(dir);
         total++;
         if (pos !== 2'(m_pos) || wrap !== m_wrap) begin
            bad++;
            $display("[TB] FAIL bounce_step_%0d: got %0d/%0b expected %0d/%0b",
                     s, pos, wrap, m_pos, m_wrap);
         end
      end
      auto_en = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_reset_mid_debounce();
      tick();
      button = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      #2;
      m_pos = 0; m_up = 1'b1; m_mode = 0;
      model_set_mode(int'(mode));
      total++;
      if (led !== 4'b0000 || pos !== 2'd0 || wrap !== 1'b0) begin
         bad++;
         $display("[TB] FAIL async_reset: got led %b pos %0d wrap %0b expected 0000/0/0", led, pos, wrap);
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (20) tick();
      total++;
      if (pos !== 2'd0 || led !== exp_led(0, m_mode)) begin
         bad++;
         $display("[TB] FAIL held_after_reset: got pos %0d led %b expected 0 %b", pos, led, exp_led(0, m_mode));
      end
      button = 1'b0;
      repeat (12) tick();
   endtask

   task automatic test_fill_down();
      mode = 2'b10; dir = 1'b1;
      model_set_mode(2);
      tick();
      press_check("fill_down_a", 10);
      total++;
      if (led !== 4'b1111) begin
         bad++;
         $display("[TB] FAIL fill_full: got %b expected 1111", led);
      end
      press_check("fill_down_b", 10);
   endtask

   task automatic test_coincident();
      mode = 2'b00; dir = 1'b0;
      model_set_mode(0);
      tick();
      tick();
      auto_en = 1'b1;
      repeat (8) tick();
      button = 1'b1;
      repeat (7) tick();
      total++;
      if (pos !== 2'(m_pos)) begin
         bad++;
         $display("[TB] FAIL coincident_before: got %0d expected %0d", pos, m_pos);
      end
      tick();
      auto_en = 1'b0;
      model_step(1'b0);
      total++;
      if (pos !== 2'(m_pos)) begin
         bad++;
         $display("[TB] FAIL coincident_step: got %0d expected %0d", pos, m_pos);
      end
      repeat (4) tick();
      button = 1'b0;
      repeat (12) tick();
      total++;
      if (pos !== 2'(m_pos)) begin
         bad++;
         $display("[TB] FAIL coincident_after: got %0d expected %0d", pos, m_pos);
      end
   endtask

   task automatic test_random();
      int md;
      for (int i = 0; i < 16; i++) begin
         md   = $urandom_range(0, 3);
         mode = 2'(md);
         dir  = 1'($urandom_range(0, 1));
         we   = ($urandom_range(0, 3) != 0);
         model_set_mode(md);
         tick();
         press_check("random", $urandom_range(9, 14));
      end
      we = 1'b1;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_rotate();
      test_glitch_and_we();
      test_bounce_auto();
      test_reset_mid_debounce();
      test_fill_down();
      test_coincident();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Parametrised successor of the four-LED one-hot stepper: drives N_LEDS outputs from a position register.
- The position advances on a debounced button press or an optional internal auto-step timer, gated by we.
- Adds selectable direction, four display modes (rotate, bounce, fill, hold) and a wrap-event pulse.
- Sits between board push-buttons/switches and the LED bank.

Parameters:
- N_LEDS, 4, number of LED outputs (>=2).
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required to accept a button level change (>=1).
- AUTO_DIV, 16, auto-step period in clock cycles (>=2).
- PW, $clog2(N_LEDS), position width (derived; not to be overridden).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- we  in  1  step enable; when 0 no step is taken from any source.
- button  in  1  raw asynchronous push-button, active high.
- dir  in  1  0 = step up (pos+1), 1 = step down (pos-1); ignored in bounce mode.
- mode  in  2  00 rotate, 01 bounce, 10 fill, 11 hold.
- auto_en  in  1  enables the internal auto-step timer.
- led  out  N_LEDS  LED drive, registered.
- pos  out  PW  current position, registered.
- wrap  out  1  one-cycle pulse on end-of-range event.

Behaviour:
- Reset (rst=0, async):
  - pos=0, led=0 (all off), wrap=0.
  - Sync flops, debounced level, previous-level flop and step pulse all 0.
  - Debounce and prescaler counters 0; bounce direction = up.
- After reset release, led reflects pos=0 per current mode on the first clock edge.
- Button path:
  - Two-flop synchroniser: s1, then s2.
  - Debounce: cnt increments while s2 != db; cnt clears to 0 when s2 == db.
  - When s2 != db and cnt == DEBOUNCE_CYCLES-1: db <= s2 and cnt <= 0.
  - btn_step is a registered one-cycle pulse on the db rising edge only. Release never steps; holding the button gives exactly one step.
- Latency: button stable high sampled first at edge 0 -> db at edge DEBOUNCE_CYCLES+1, btn_step at +2, pos at +3, led at +4. With default 4 this is edge 8.
- Auto timer:
  - Prescaler counts 0..AUTO_DIV-1 while auto_en=1 and wraps to 0; auto_tick=1 for the cycle it equals AUTO_DIV-1.
  - auto_en=0 holds the prescaler at 0.
- Step condition: step = we & (btn_step | auto_tick). Simultaneous btn_step and auto_tick produce a single step. we=0 discards the request; no queuing.
- pos update on step:
  - rotate/fill: modular ±1, so N_LEDS-1 -> 0 up and 0 -> N_LEDS-1 down; wrap=1 on that edge.
  - bounce: move per internal direction. Reaching N_LEDS-1 going up or 0 going down flips the direction; wrap=1 on the reversal step. Sequence for N=4: 0,1,2,3,2,1,0,1...
  - hold: pos unchanged, wrap=0, prescaler still runs.
- led (registered from pos, one cycle later):
  - rotate/bounce/hold: one-hot, led[pos]=1.
  - fill: led[i]=1 for all i<=pos.
- Mode change mid-operation: pos is preserved and the led pattern updates on the next edge. Entering bounce sets bounce direction to up unless pos==N_LEDS-1, in which case it is down.
- Non-power-of-two N_LEDS: pos never exceeds N_LEDS-1. Any out-of-range value is forced to 0 on the next edge.
- wrap defaults to 0 every cycle it is not asserted.
- Reset asserted mid-debounce or mid-step: all state clears immediately. A held button must be released and pressed again to step.

Test Plan:
- Reset then release, mode=00, no press -> led=0001 one edge after release, pos=0, wrap=0.
- we=1, dir=0, mode=00, four clean presses held 10 cycles each -> led 0010, 0100, 1000, 0001; wrap pulses once on the 3->0 step; each led change lands at edge 8 after press.
- Button glitch high for 2 cycles with DEBOUNCE_CYCLES=4 -> no step. Press with we=0 -> no step, pos unchanged.
- mode=01, auto_en=1, AUTO_DIV=16, we=1 -> pos 0,1,2,3,2,1,0,1 every 16 cycles; wrap on steps to 3 and to 0.
- mode=10, dir=1 from pos=0, one press -> pos=3, led=1111, wrap=1. Next press -> pos=2, led=0111.
- auto_tick and btn_step coincident -> pos changes by exactly 1. rst pulled low mid-debounce -> led=0000 asynchronously, no step after release while button stays high.
